mtwo_seq: RTL and testbench

//   Run sequencer for the mTWO functional unit. Takes one start/length job and drives the mTWO init and in_disable inputs.

---
 rtl/mtwo_seq_pkg.sv | 34 +++
 rtl/mtwo_seq_tmr.sv | 28 ++
 rtl/mtwo_seq.sv | 192 +++++++++++++++++++
 tb/tb_mtwo_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtwo_seq_pkg.sv
// Shared types and defaults for the mTWO run sequencer.
// State encoding, default widths and timer-width helpers used by mtwo_seq and mtwo_seq_tmr.
package mtwo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seqState_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_INIT_CYC    = 1;
  localparam int DEF_DRAIN_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 256;

  // Width of a down-counter that must hold values up to cycles
  function automatic int tmrWidth(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  localparam int DEF_TO_W = tmrWidth(DEF_TIMEOUT_CYC);

  // INIT/RUN/DRAIN: a job is in flight and the FU is owned by the sequencer
  function automatic logic isActive(input seqState_t s);
    return (s == INIT) || (s == RUN) || (s == DRAIN);
  endfunction

  function automatic logic isRunPhase(input seqState_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/mtwo_seq_tmr.sv
// Loadable down-counter with enable and zero flag; used as phase timer and watchdog.
// Load wins over enable; the count stops at zero instead of wrapping.
module mtwo_seq_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cntReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntReg <= '0;
    end else if (load) begin
      cntReg <= loadVal;
    end else if (en && (cntReg != '0)) begin
      cntReg <= cntReg - W'(1);
    end
  end

  assign zero = (cntReg == '0);

endmodule

// File: rtl/mtwo_seq.sv
// Run sequencer for one mTWO functional unit: INIT -> counted RUN -> DRAIN -> DONE pulse.
// Optional stall watchdog enabled by defining MTWO_SEQ_TIMEOUT_EN.
module mtwo_seq
  import mtwo_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int INIT_CYC    = DEF_INIT_CYC,
  parameter int DRAIN_CYC   = DEF_DRAIN_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             mtwo_seq_clk,
  input  logic             mtwo_seq_reset,
  input  logic             mtwo_seq_start,
  input  logic [CNT_W-1:0] mtwo_seq_len,
  input  logic             mtwo_seq_hold,
  input  logic             mtwo_seq_abort,
  output logic             mtwo_seq_ready,
  output logic             mtwo_seq_busy,
  output logic             mtwo_seq_done,
  output logic [CNT_W-1:0] mtwo_seq_count,
  output logic             mtwo_seq_fu_init,
  output logic             mtwo_seq_fu_dis,
  output logic             mtwo_seq_err
);

  localparam int INIT_W  = tmrWidth(INIT_CYC);
  localparam int DRAIN_W = tmrWidth(DRAIN_CYC);

  if (INIT_CYC < 1) begin : gBadInitCyc
    $error("mtwo_seq: INIT_CYC must be at least 1");
  end
  if (DRAIN_CYC < 1) begin : gBadDrainCyc
    $error("mtwo_seq: DRAIN_CYC must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : gBadTimeoutCyc
    $error("mtwo_seq: TIMEOUT_CYC must be at least 1");
  end

  seqState_t        stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [CNT_W-1:0] lenReg, lenNext;

  logic readyReg, busyReg, doneReg, fuInitReg, runGateReg;
  logic initLoad, initEn, initZero;
  logic drainLoad, drainEn, drainZero;
  logic accept;
  logic wdTrip;

  assign accept = (stateReg == IDLE) && mtwo_seq_start;

  mtwo_seq_tmr #(.W(INIT_W)) uInitTmr (
    .clk     (mtwo_seq_clk),
    .rst     (mtwo_seq_reset),
    .load    (initLoad),
    .loadVal (INIT_W'(INIT_CYC - 1)),
    .en      (initEn),
    .zero    (initZero)
  );

  mtwo_seq_tmr #(.W(DRAIN_W)) uDrainTmr (
    .clk     (mtwo_seq_clk),
    .rst     (mtwo_seq_reset),
    .load    (drainLoad),
    .loadVal (DRAIN_W'(DRAIN_CYC - 1)),
    .en      (drainEn),
    .zero    (drainZero)
  );

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    lenNext   = lenReg;
    initLoad  = 1'b0;
    initEn    = 1'b0;
    drainLoad = 1'b0;
    drainEn   = 1'b0;

    case (stateReg)
      IDLE: begin
        if (mtwo_seq_start) begin
          lenNext   = mtwo_seq_len;
          cntNext   = '0;
          initLoad  = 1'b1;
          stateNext = (mtwo_seq_len == '0) ? DONE : INIT;
        end
      end
      INIT: begin
        if (initZero) begin
          stateNext = RUN;
        end else begin
          initEn = 1'b1;
        end
      end
      RUN: begin
        // The increment that lands on len is also the last run cycle
        if (!mtwo_seq_hold && (cntReg != lenReg)) begin
          cntNext = cntReg + CNT_W'(1);
          if (cntReg + CNT_W'(1) == lenReg) begin
            stateNext = DRAIN;
            drainLoad = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!mtwo_seq_hold) begin
          if (drainZero) begin
            stateNext = DONE;
          end else begin
            drainEn = 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Abort and watchdog trip override everything; the progress count is kept
    if (isActive(stateReg) && (mtwo_seq_abort || wdTrip)) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge mtwo_seq_clk or posedge mtwo_seq_reset) begin
    if (mtwo_seq_reset) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      lenReg     <= '0;
      readyReg   <= 1'b1;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      fuInitReg  <= 1'b0;
      runGateReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      cntReg     <= cntNext;
      lenReg     <= lenNext;
      readyReg   <= (stateNext == IDLE);
      busyReg    <= isActive(stateNext);
      doneReg    <= (stateNext == DONE);
      fuInitReg  <= (stateNext == INIT);
      runGateReg <= isRunPhase(stateNext);
    end
  end

  assign mtwo_seq_ready   = readyReg;
  assign mtwo_seq_busy    = busyReg;
  assign mtwo_seq_done    = doneReg;
  assign mtwo_seq_count   = cntReg;
  assign mtwo_seq_fu_init = fuInitReg;
  // Stall must freeze the FU in the same cycle, so hold gates the registered run-phase flag
  assign mtwo_seq_fu_dis  = !runGateReg || mtwo_seq_hold;

`ifdef MTWO_SEQ_TIMEOUT_EN
  localparam int TO_W = tmrWidth(TIMEOUT_CYC);

  logic wdStall, wdZero, errReg;

  assign wdStall = isRunPhase(stateReg) && mtwo_seq_hold;

  // Reloaded on every unstalled cycle, so it only ever measures consecutive stalls
  mtwo_seq_tmr #(.W(TO_W)) uWatchdog (
    .clk     (mtwo_seq_clk),
    .rst     (mtwo_seq_reset),
    .load    (!wdStall),
    .loadVal (TO_W'(TIMEOUT_CYC - 1)),
    .en      (wdStall),
    .zero    (wdZero)
  );

  assign wdTrip = wdStall && wdZero;

  always_ff @(posedge mtwo_seq_clk or posedge mtwo_seq_reset) begin
    if (mtwo_seq_reset) begin
      errReg <= 1'b0;
    end else if (wdTrip) begin
      errReg <= 1'b1;
    end else if (accept) begin
      errReg <= 1'b0;
    end
  end

  assign mtwo_seq_err = errReg;
`else
  assign wdTrip       = 1'b0;
  assign mtwo_seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_mtwo_seq.sv
// Self-checking bench for mtwo_seq (INIT_CYC=1, DRAIN_CYC=2, TIMEOUT_CYC=8).
// Cycle 0 is the cycle a start is driven; checks sample 1-2 ns after each rising edge.
module tb_mtwo_seq;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic             ready, busy, done, fuInit, fuDis, err;
  logic [CNT_W-1:0] count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int cnt;
    int doneCyc;
  } exp_t;

  exp_t sbQ[$];

  always #5 clk = ~clk;

  mtwo_seq #(
    .CNT_W       (CNT_W),
    .INIT_CYC    (1),
    .DRAIN_CYC   (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .mtwo_seq_clk     (clk),
    .mtwo_seq_reset   (rst),
    .mtwo_seq_start   (start),
    .mtwo_seq_len     (len),
    .mtwo_seq_hold    (hold),
    .mtwo_seq_abort   (abort),
    .mtwo_seq_ready   (ready),
    .mtwo_seq_busy    (busy),
    .mtwo_seq_done    (done),
    .mtwo_seq_count   (count),
    .mtwo_seq_fu_init (fuInit),
    .mtwo_seq_fu_dis  (fuDis),
    .mtwo_seq_err     (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({ready, busy, done, fuInit, fuDis, err} !== 6'b100010 || count !== '0) begin
      mismatched++;
      $display("FAIL reset_values got rdy/bsy/dn/ini/dis/err=%b cnt=%0d exp=100010 cnt=0",
               {ready, busy, done, fuInit, fuDis, err}, count);
    end
    rst = 1'b0;
    start = 1'b1; len = 16'd10;
    tick();
    start = 1'b0;
    repeat (3) tick();
    compared++;
    if (busy !== 1'b1 || fuDis !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_prejob busy=%b fu_dis=%b exp busy=1 fu_dis=0", busy, fuDis);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({ready, busy, done, fuInit, fuDis} !== 5'b10001 || count !== '0) begin
      mismatched++;
      $display("FAIL reset_midrun got rdy/bsy/dn/ini/dis=%b cnt=%0d exp=10001 cnt=0",
               {ready, busy, done, fuInit, fuDis}, count);
    end
    #1 rst = 1'b0;
    tick();
    compared++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release ready=%b busy=%b done=%b exp 1 0 0", ready, busy, done);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    start = 1'b1; len = 16'd3;
    e.cnt = 3; e.doneCyc = 7; sbQ.push_back(e);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      compared++;
      if (fuInit !== 1'(c == 1) || fuDis !== 1'(!(c >= 2 && c <= 6))) begin
        mismatched++;
        $display("FAIL basic_fu cyc=%0d fu_init=%b fu_dis=%b exp %b %b",
                 c, fuInit, fuDis, 1'(c == 1), 1'(!(c >= 2 && c <= 6)));
      end
      compared++;
      if (done !== 1'(c == 7) || ready !== 1'(c == 8) || busy !== 1'(c <= 6)) begin
        mismatched++;
        $display("FAIL basic_ctl cyc=%0d done=%b ready=%b busy=%b exp %b %b %b",
                 c, done, ready, busy, 1'(c == 7), 1'(c == 8), 1'(c <= 6));
      end
      if (done === 1'b1 && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        $display("job done: len=3 cyc=%0d count=%0d", c, count);
        compared++;
        if (count !== CNT_W'(e.cnt) || c != e.doneCyc) begin
          mismatched++;
          $display("FAIL basic_sb cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", count, c, e.cnt, e.doneCyc);
        end
      end
      if (c < 8) tick();
    end
    tick();
  endtask

  task automatic test_len_zero();
    exp_t e;
    start = 1'b1; len = 16'd0;
    e.cnt = 0; e.doneCyc = 1; sbQ.push_back(e);
    tick();
    for (int c = 1; c <= 3; c++) begin
      // start during DONE must be ignored
      start = 1'(c == 1); len = 16'd5;
      #1;
      compared++;
      if (fuInit !== 1'b0 || busy !== 1'b0 || count !== '0 || done !== 1'(c == 1) || ready !== 1'(c >= 2)) begin
        mismatched++;
        $display("FAIL len0 cyc=%0d ini=%b bsy=%b cnt=%0d dn=%b rdy=%b exp 0 0 0 %b %b",
                 c, fuInit, busy, count, done, ready, 1'(c == 1), 1'(c >= 2));
      end
      if (done === 1'b1 && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        $display("job done: len=0 cyc=%0d count=%0d", c, count);
        compared++;
        if (count !== CNT_W'(e.cnt) || c != e.doneCyc) begin
          mismatched++;
          $display("FAIL len0_sb cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", count, c, e.cnt, e.doneCyc);
        end
      end
      if (c == 1) start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_hold();
    exp_t e;
    start = 1'b1; len = 16'd4;
    e.cnt = 4; e.doneCyc = 10; sbQ.push_back(e);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      hold = 1'(c == 3 || c == 4);
      #1;
      compared++;
      if (fuDis !== 1'(c == 1 || c == 3 || c == 4 || c >= 10) || done !== 1'(c == 10)) begin
        mismatched++;
        $display("FAIL hold_fu cyc=%0d fu_dis=%b done=%b exp %b %b",
                 c, fuDis, done, 1'(c == 1 || c == 3 || c == 4 || c >= 10), 1'(c == 10));
      end
      if (c == 4 || c == 6 || c == 11) begin
        compared++;
        if (count !== ((c == 4) ? 16'd1 : (c == 6) ? 16'd2 : 16'd4)) begin
          mismatched++;
          $display("FAIL hold_count cyc=%0d count=%0d", c, count);
        end
      end
      if (done === 1'b1 && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        $display("job done: len=4 stalled cyc=%0d count=%0d", c, count);
        compared++;
        if (count !== CNT_W'(e.cnt) || c != e.doneCyc) begin
          mismatched++;
          $display("FAIL hold_sb cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", count, c, e.cnt, e.doneCyc);
        end
      end
      tick();
    end
    hold = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1; len = 16'd10;
    tick();
    for (int c = 1; c <= 12; c++) begin
      start = 1'(c == 4);
      len   = (c == 4) ? 16'd2 : 16'd10;
      abort = 1'(c == 5);
      #1;
      compared++;
      if (done !== 1'b0 || ready !== 1'(c >= 6) || busy !== 1'(c <= 5)) begin
        mismatched++;
        $display("FAIL abort_ctl cyc=%0d done=%b ready=%b busy=%b exp 0 %b %b",
                 c, done, ready, busy, 1'(c >= 6), 1'(c <= 5));
      end
      if (c == 6 || c == 12) begin
        compared++;
        if (count !== 16'd4 || fuDis !== 1'b1) begin
          mismatched++;
          $display("FAIL abort_count cyc=%0d count=%0d fu_dis=%b exp 4 1", c, count, fuDis);
        end
      end
      tick();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lens[3] = '{1, 5, 2};
    exp_t e;
    for (int j = 0; j < 3; j++) begin
      compared++;
      if (ready !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_ready job=%0d ready=%b exp 1", j, ready);
      end
      start = 1'b1; len = CNT_W'(lens[j]);
      e.cnt = lens[j]; e.doneCyc = lens[j] + 4; sbQ.push_back(e);
      tick();
      start = 1'b0;
      for (int c = 1; c <= lens[j] + 4; c++) begin
        #1;
        compared++;
        if (done !== 1'(c == lens[j] + 4) || busy !== 1'(c <= lens[j] + 3)) begin
          mismatched++;
          $display("FAIL b2b_ctl job=%0d cyc=%0d done=%b busy=%b", j, c, done, busy);
        end
        if (done === 1'b1 && sbQ.size() > 0) begin
          e = sbQ.pop_front();
          $display("job done: len=%0d cyc=%0d count=%0d", lens[j], c, count);
          compared++;
          if (count !== CNT_W'(e.cnt) || c != e.doneCyc) begin
            mismatched++;
            $display("FAIL b2b_sb cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", count, c, e.cnt, e.doneCyc);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_timeout();
    start = 1'b1; len = 16'd20;
    tick();
    start = 1'b0;
`ifdef MTWO_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 12; c++) begin
      hold = 1'(c >= 3);
      #1;
      compared++;
      if (done !== 1'b0 || err !== 1'(c >= 11) || ready !== 1'(c >= 11)) begin
        mismatched++;
        $display("FAIL timeout cyc=%0d done=%b err=%b ready=%b exp 0 %b %b",
                 c, done, err, ready, 1'(c >= 11), 1'(c >= 11));
      end
      tick();
    end
    hold = 1'b0; start = 1'b1; len = 16'd1;
    tick();
    start = 1'b0;
    compared++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_clear err=%b busy=%b exp 0 1", err, busy);
    end
    repeat (5) tick();
`else
    for (int c = 1; c <= 40; c++) begin
      hold = 1'(c >= 3);
      #1;
      compared++;
      if (done !== 1'b0 || err !== 1'b0 || (c >= 3 && (busy !== 1'b1 || fuDis !== 1'b1))) begin
        mismatched++;
        $display("FAIL stall cyc=%0d done=%b err=%b busy=%b fu_dis=%b exp 0 0 1 1",
                 c, done, err, busy, fuDis);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0;
    compared++;
    if (ready !== 1'b1 || count !== 16'd1) begin
      mismatched++;
      $display("FAIL stall_abort ready=%b count=%0d exp 1 1", ready, count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_hold();
    test_abort();
    test_back_to_back();
    test_timeout();
    compared++;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty pending=%0d exp 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
